hdb3_rx_ctrl: RTL and testbench
===============================

Name: hdb3_rx_ctrl

Overview:
Receive-path controller for the HDB3 decoder chain. It watches the same 2-bit symbol stream that feeds the V/B-removal stage and checks it for HDB3 code violations. It runs the flush/hunt/lock/loss-of-signal sequence and drives the decoder's clear and enable. It also qualifies the decoded output with a valid strobe and keeps a saturating error counter.

Parameters:
PIPE_LAT, 5, decoder pipeline depth in symbols; sets the flush length.
LOCK_GOOD, 32, consecutive error-free symbols needed in HUNT to declare lock.
ERR_WIN, 64, LOCKED error-window length in symbols.
UNLOCK_ERR, 4, errors within one window that force relock.
LOS_ZEROS, 16, consecutive zero symbols that declare loss of signal.
ERR_CNT_W, 16, Err_Count width.

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous reset, active-high
Sym_En  in  1  symbol strobe; Hdb3_In is valid when high
Hdb3_In  in  2  symbol: 00 zero, 01 positive pulse, 10 negative pulse, 11 illegal
Err_Clr  in  1  clears Err_Count
Dec_Clr  out  1  flush request to the decoder pipeline
Dec_En  out  1  decoder symbol enable; equals Sym_En gated by not FLUSH
Data_Valid  out  1  decoded output qualifier
Lock  out  1  high in LOCKED
Los  out  1  high in LOS
Code_Err  out  1  one-cycle pulse per violating symbol
Err_Count  out  ERR_CNT_W  saturating violation count

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset values: FSM goes to FLUSH. Dec_Clr=1. All other outputs are 0. Checker history is cleared: last pulse polarity=none, last V polarity=none, zero run=0.
- Update timing: state only advances on Clk edges where Sym_En=1, with one exception. Err_Clr acts on any edge.
- Registered outputs (Dec_Clr, Data_Valid, Lock, Los, Code_Err, Err_Count) reflect the strobe sampled on the previous edge.
- Dec_En is combinational: Sym_En AND (state != FLUSH).
- Violation checker. A symbol is a violation if any of the following holds:
  - (a) the symbol is 11;
  - (b) it is the 4th or later consecutive zero;
  - (c) it is a pulse with the same polarity as the previous pulse, and the preceding zero run is neither 3 (000V) nor 2 (B00V);
  - (d) it is a legal same-polarity pulse (a V) with the same polarity as the previous V.
- A legal V updates the last-V polarity. Any pulse updates the last-pulse polarity and clears the zero run.
- The first pulse after reset or flush is never a violation under rule (c) or (d).
- Code_Err fires one cycle after the strobe that carried the violation.
- FSM states and transitions:
  - FLUSH: Dec_Clr=1. Counts PIPE_LAT strobes, then goes to HUNT. Checker history is held cleared.
  - HUNT: counts consecutive error-free strobes. Any violation resets the count to 0. When the count reaches LOCK_GOOD, go to LOCKED.
  - LOCKED: Lock=1. Data_Valid pulses one cycle after each strobe.
    - The error window counter wraps every ERR_WIN strobes and clears the window error tally at the wrap.
    - When the tally reaches UNLOCK_ERR, go to FLUSH.
  - LOS: Los=1 and Data_Valid=0. The first pulse symbol (01 or 10) goes to FLUSH. Symbol 11 stays in LOS and counts as an error.
  - From HUNT or LOCKED: a zero run reaching LOS_ZEROS goes to LOS. LOS takes priority over an unlock on the same strobe.
- Lock and Data_Valid drop on the edge that leaves LOCKED. No trailing Data_Valid is produced.
- Err_Count:
  - Increments on each violation, in every state except FLUSH.
  - Saturates at all-ones.
  - Err_Clr together with a violation on the same edge gives Err_Count=1.
- Reset mid-operation: Rst overrides everything on that edge, including Err_Clr and Sym_En.

Decomposition:
- Package hdb3_pkg: symbol constants SYM_ZERO/SYM_POS/SYM_NEG/SYM_BAD, the FSM state enum (FLUSH, HUNT, LOCKED, LOS), and the checker history record type.
- Sub-module hdb3_cv_check: the violation checker. It takes the symbol, strobe and a clear input, and outputs the violation flag and zero-run count.

Test Plan:
- Reset: Rst high for 3 cycles. Required: Dec_Clr=1, Lock=0, Los=0, Err_Count=0. After 5 strobes, Dec_Clr=0 (HUNT).
- Clean lock: legal HDB3 stream for the input 1,0,0,0,0,1 repeated, with Sym_En every cycle. Required: Lock rises exactly 1+5+32 strobes after reset release. Data_Valid then tracks Sym_En with 1-cycle delay. Err_Count stays 0.
- Violations: inject 01,00,00,00,00 (rule b), then 01,01 with zero run 0 (rule c), then a V repeating the prior V polarity (rule d). Required: one Code_Err pulse each, and Err_Count=3.
- Unlock: while LOCKED, inject 4 single-symbol 11 errors within 64 strobes. Required: Lock=0 and Dec_Clr=1 on the cycle after the 4th. Relock follows after 5+32 clean strobes. 3 errors spread over two windows must not unlock.
- LOS and recovery: 16 zeros in LOCKED. Required: Los=1 after the 16th strobe, Data_Valid=0. A subsequent 10 symbol gives Los=0 and FLUSH.
- Corner cases:
  - Err_Clr asserted together with a violation gives Err_Count=1.
  - Force Err_Count to all-ones, then add one violation: Err_Count holds at all-ones.
  - Rst asserted in LOCKED returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared symbol codes, controller states and violation-checker history for the HDB3 receive path.
package hdb3_pkg;
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;
  localparam logic [1:0] SYM_BAD  = 2'b11;

  localparam int ZRUN_W = 8;

  typedef enum logic [1:0] {FLUSH, HUNT, LOCKED, LOS} rx_state_e;

  // Polarity fields reuse the pulse symbol codes; SYM_ZERO means no pulse/V seen yet.
  typedef struct packed {
    logic [1:0]        last_pol;
    logic [1:0]        last_v;
    logic [ZRUN_W-1:0] zrun;
  } cv_hist_t;

  function automatic logic is_pulse(input logic [1:0] s);
    return (s == SYM_POS) || (s == SYM_NEG);
  endfunction
endpackage

// File: rtl/hdb3_rx_ctrl_cv_check.sv
// HDB3 code-violation checker: flags bad symbols, long zero runs, bad repeats and repeated V polarity.
module hdb3_cv_check
  import hdb3_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              sym_en,
  input  logic [1:0]        sym,
  input  logic              clr,
  output logic              viol,
  output logic [ZRUN_W-1:0] zero_run
);
  cv_hist_t hist, hist_nxt;
  logic     same_pol, v_pos;

  always_comb begin
    hist_nxt = hist;
    viol     = 1'b0;
    same_pol = is_pulse(sym) && (sym == hist.last_pol);
    v_pos    = (hist.zrun == ZRUN_W'(2)) || (hist.zrun == ZRUN_W'(3));
    case (sym)
      SYM_ZERO: begin
        viol = hist.zrun >= ZRUN_W'(3);
        if (hist.zrun != '1) hist_nxt.zrun = hist.zrun + ZRUN_W'(1);
      end
      SYM_POS, SYM_NEG: begin
        // A repeat after 000 or B00 is a V; anything else repeating is an error.
        if (same_pol && v_pos) begin
          viol            = (sym == hist.last_v);
          hist_nxt.last_v = sym;
        end else begin
          viol = same_pol;
        end
        hist_nxt.last_pol = sym;
        hist_nxt.zrun     = '0;
      end
      SYM_BAD: begin
        viol          = 1'b1;
        hist_nxt.zrun = '0;
      end
    endcase
    if (!sym_en || clr) begin
      viol     = 1'b0;
      hist_nxt = hist;
    end
    zero_run = hist_nxt.zrun;
  end

  always_ff @(posedge Clk) begin
    if (Rst || clr) hist <= '0;
    else            hist <= hist_nxt;
  end
endmodule

// File: rtl/hdb3_rx_ctrl.sv
// HDB3 receive controller: flush/hunt/lock/LOS sequencing, decoder clear/enable, valid and error count.
module hdb3_rx_ctrl
  import hdb3_pkg::*;
#(
  parameter int PIPE_LAT   = 5,
  parameter int LOCK_GOOD  = 32,
  parameter int ERR_WIN    = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int LOS_ZEROS  = 16,
  parameter int ERR_CNT_W  = 16
)(
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Sym_En,
  input  logic [1:0]           Hdb3_In,
  input  logic                 Err_Clr,
  output logic                 Dec_Clr,
  output logic                 Dec_En,
  output logic                 Data_Valid,
  output logic                 Lock,
  output logic                 Los,
  output logic                 Code_Err,
  output logic [ERR_CNT_W-1:0] Err_Count
);
  localparam int FL_W = $clog2(PIPE_LAT + 1);
  localparam int GD_W = $clog2(LOCK_GOOD + 1);
  localparam int WN_W = $clog2(ERR_WIN + 1);
  localparam int TL_W = $clog2(UNLOCK_ERR + 1);

  rx_state_e         state, state_nxt;
  logic [FL_W-1:0]   flush_cnt, flush_nxt;
  logic [GD_W-1:0]   good_cnt, good_nxt;
  logic [WN_W-1:0]   win_cnt, win_nxt;
  logic [TL_W-1:0]   tally, tally_nxt, tally_sum;
  logic              viol, los_hit, win_err, win_wrap;
  logic [ZRUN_W-1:0] zero_run;

  logic                 dec_clr_d, lock_d, los_d, dv_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  hdb3_cv_check u_cv (
    .Clk      (Clk),
    .Rst      (Rst),
    .sym_en   (Sym_En),
    .sym      (Hdb3_In),
    .clr      (state == FLUSH),
    .viol     (viol),
    .zero_run (zero_run)
  );

  assign los_hit  = Sym_En && (Hdb3_In == SYM_ZERO) && (zero_run >= ZRUN_W'(LOS_ZEROS));
  // Long zero runs are handled by the LOS path, so they do not feed the unlock tally.
  assign win_err  = viol && (Hdb3_In != SYM_ZERO);
  assign win_wrap = (win_cnt == WN_W'(ERR_WIN - 1));
  assign tally_sum = tally + TL_W'(win_err);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      good_cnt  <= '0;
      win_cnt   <= '0;
      tally     <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      good_cnt  <= good_nxt;
      win_cnt   <= win_nxt;
      tally     <= tally_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    good_nxt  = good_cnt;
    win_nxt   = win_cnt;
    tally_nxt = tally;
    if (Sym_En) begin
      case (state)
        FLUSH: begin
          if (flush_cnt == FL_W'(PIPE_LAT - 1)) begin
            state_nxt = HUNT;
            flush_nxt = '0;
          end else begin
            flush_nxt = flush_cnt + FL_W'(1);
          end
        end
        HUNT: begin
          good_nxt = good_cnt + GD_W'(1);
          if (los_hit) begin
            state_nxt = LOS;
            good_nxt  = '0;
          end else if (viol) begin
            good_nxt = '0;
          end else if (good_cnt == GD_W'(LOCK_GOOD - 1)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end
        end
        LOCKED: begin
          win_nxt   = win_wrap ? '0 : win_cnt + WN_W'(1);
          tally_nxt = win_wrap ? '0 : tally_sum;
          if (los_hit)                               state_nxt = LOS;
          else if (tally_sum >= TL_W'(UNLOCK_ERR))   state_nxt = FLUSH;
          if (state_nxt != LOCKED) begin
            win_nxt   = '0;
            tally_nxt = '0;
          end
        end
        LOS: begin
          if (is_pulse(Hdb3_In)) state_nxt = FLUSH;
        end
      endcase
    end
  end

  always_comb begin
    Dec_En    = Sym_En && (state != FLUSH);
    dec_clr_d = (state_nxt == FLUSH);
    lock_d    = (state_nxt == LOCKED);
    los_d     = (state_nxt == LOS);
    dv_d      = Sym_En && (state == LOCKED) && (state_nxt == LOCKED);
    err_cnt_d = Err_Count;
    if (Err_Clr)                    err_cnt_d = ERR_CNT_W'(viol);
    else if (viol && !(&Err_Count)) err_cnt_d = Err_Count + ERR_CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Dec_Clr    <= 1'b1;
      Lock       <= 1'b0;
      Los        <= 1'b0;
      Data_Valid <= 1'b0;
      Code_Err   <= 1'b0;
      Err_Count  <= '0;
    end else begin
      Dec_Clr    <= dec_clr_d;
      Lock       <= lock_d;
      Los        <= los_d;
      Data_Valid <= dv_d;
      Code_Err   <= viol;
      Err_Count  <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_hdb3_rx_ctrl.sv
// Directed bench for hdb3_rx_ctrl: reset, lock timing, violation rules, unlock, LOS and counter corners.
module tb_hdb3_rx_ctrl;
  import hdb3_pkg::*;

  logic       Clk, Rst, Sym_En, Err_Clr;
  logic [1:0] Hdb3_In;
  logic       Dec_Clr, Dec_En, Data_Valid, Lock, Los, Code_Err;
  logic [4:0] Err_Count;

  int checks   = 0;
  int failures = 0;
  int p        = 0;

  // Violation sequence from an empty history: rule b at 5, rule c at 8, rule d at 18.
  logic [1:0] vsym [18] = '{SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_NEG,
                            SYM_POS, SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS,
                            SYM_NEG, SYM_POS, SYM_ZERO, SYM_ZERO, SYM_ZERO, SYM_POS};
  logic       vexp [18] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  hdb3_rx_ctrl #(.ERR_CNT_W(5)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Sym_En     (Sym_En),
    .Hdb3_In    (Hdb3_In),
    .Err_Clr    (Err_Clr),
    .Dec_Clr    (Dec_Clr),
    .Dec_En     (Dec_En),
    .Data_Valid (Data_Valid),
    .Lock       (Lock),
    .Los        (Los),
    .Code_Err   (Code_Err),
    .Err_Count  (Err_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en, input logic [1:0] s);
    Sym_En  = en;
    Hdb3_In = s;
    @(posedge Clk);
    #1;
    Sym_En  = 1'b0;
    Hdb3_In = SYM_ZERO;
  endtask

  // HDB3 encoding of data 1,0,0,0,0,1 repeated: +,0,0,0,V+ then a 12-symbol period.
  function automatic logic [1:0] clean_sym(input int n);
    int k;
    if (n < 5) return (n == 0 || n == 4) ? SYM_POS : SYM_ZERO;
    k = (n - 5) % 12;
    case (k)
      0, 2, 5, 7:  return SYM_NEG;
      1, 6, 8, 11: return SYM_POS;
      default:     return SYM_ZERO;
    endcase
  endfunction

  task automatic send_clean(input int count);
    for (int i = 0; i < count; i++) begin
      tick(1'b1, clean_sym(p));
      p++;
    end
  endtask

  initial begin
    Rst = 1'b1; Sym_En = 1'b0; Hdb3_In = SYM_ZERO; Err_Clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_dec_clr", Dec_Clr, 1);
    chk("rst_lock", Lock, 0);
    chk("rst_los", Los, 0);
    chk("rst_err_cnt", Err_Count, 0);
    chk("rst_dv", Data_Valid, 0);
    chk("rst_code_err", Code_Err, 0);
    Rst = 1'b0;
    Sym_En = 1'b1; #1;
    chk("dec_en_flush", Dec_En, 0);
    Sym_En = 1'b0;
    repeat (4) tick(1'b1, SYM_ZERO);
    chk("flush_4_dec_clr", Dec_Clr, 1);
    tick(1'b1, SYM_ZERO);
    chk("flush_5_dec_clr", Dec_Clr, 0);
    Sym_En = 1'b1; #1;
    chk("dec_en_hunt", Dec_En, 1);
    Sym_En = 1'b0;

    for (int i = 0; i < 18; i++) begin
      tick(1'b1, vsym[i]);
      chk($sformatf("viol_code_err_%0d", i), Code_Err, vexp[i]);
    end
    chk("viol_err_cnt", Err_Count, 3);
    chk("viol_no_lock", Lock, 0);

    Rst = 1'b1; tick(1'b0, SYM_ZERO); Rst = 1'b0;
    chk("rst2_err_cnt", Err_Count, 0);
    tick(1'b0, SYM_ZERO);
    repeat (5) tick(1'b1, SYM_ZERO);
    p = 0;
    send_clean(31);
    chk("lock_before", Lock, 0);
    send_clean(1);
    chk("lock_rise", Lock, 1);
    chk("lock_err_cnt", Err_Count, 0);
    send_clean(1);
    chk("dv_strobe", Data_Valid, 1);
    tick(1'b0, SYM_ZERO);
    chk("dv_idle", Data_Valid, 0);
    send_clean(1);
    chk("dv_strobe2", Data_Valid, 1);

    send_clean(1);
    tick(1'b1, SYM_BAD);
    chk("win0_err1_code_err", Code_Err, 1);
    chk("win0_err1_lock", Lock, 1);
    send_clean(1);
    chk("win0_clean_code_err", Code_Err, 0);
    tick(1'b1, SYM_BAD);
    send_clean(59);
    tick(1'b1, SYM_BAD);
    send_clean(1);
    tick(1'b1, SYM_BAD);
    chk("two_windows_lock", Lock, 1);
    send_clean(1);
    tick(1'b1, SYM_BAD);
    chk("win1_err3_lock", Lock, 1);
    send_clean(4);
    chk("win1_pre4_lock", Lock, 1);
    tick(1'b1, SYM_BAD);
    chk("unlock_lock", Lock, 0);
    chk("unlock_dec_clr", Dec_Clr, 1);
    chk("unlock_dv", Data_Valid, 0);
    chk("unlock_err_cnt", Err_Count, 6);

    repeat (5) tick(1'b1, SYM_ZERO);
    chk("relock_hunt", Dec_Clr, 0);
    p = 0;
    send_clean(31);
    chk("relock_before", Lock, 0);
    send_clean(1);
    chk("relock_rise", Lock, 1);

    repeat (15) tick(1'b1, SYM_ZERO);
    chk("zeros15_los", Los, 0);
    chk("zeros15_lock", Lock, 1);
    chk("zeros15_dv", Data_Valid, 1);
    tick(1'b1, SYM_ZERO);
    chk("zeros16_los", Los, 1);
    chk("zeros16_lock", Lock, 0);
    chk("zeros16_dv", Data_Valid, 0);
    tick(1'b1, SYM_ZERO);
    chk("los_zero_dv", Data_Valid, 0);
    tick(1'b1, SYM_BAD);
    chk("los_bad_los", Los, 1);
    chk("los_bad_code_err", Code_Err, 1);
    tick(1'b1, SYM_NEG);
    chk("los_exit_los", Los, 0);
    chk("los_exit_dec_clr", Dec_Clr, 1);
    chk("los_err_cnt", Err_Count, 22);

    repeat (5) tick(1'b1, SYM_ZERO);
    Err_Clr = 1'b1; tick(1'b1, SYM_BAD); Err_Clr = 1'b0;
    chk("clr_with_viol", Err_Count, 1);
    Err_Clr = 1'b1; tick(1'b0, SYM_ZERO); Err_Clr = 1'b0;
    chk("clr_no_strobe", Err_Count, 0);
    repeat (31) tick(1'b1, SYM_BAD);
    chk("sat_reach", Err_Count, 31);
    tick(1'b1, SYM_BAD);
    chk("sat_hold", Err_Count, 31);
    chk("sat_code_err", Code_Err, 1);

    p = 0;
    send_clean(32);
    chk("pre_rst_lock", Lock, 1);
    Rst = 1'b1; Sym_En = 1'b1; Hdb3_In = SYM_BAD;
    @(posedge Clk); #1;
    Rst = 1'b0; Sym_En = 1'b0; Hdb3_In = SYM_ZERO;
    chk("midrst_dec_clr", Dec_Clr, 1);
    chk("midrst_lock", Lock, 0);
    chk("midrst_los", Los, 0);
    chk("midrst_dv", Data_Valid, 0);
    chk("midrst_code_err", Code_Err, 0);
    chk("midrst_err_cnt", Err_Count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
